ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 21 ++
 rtl/ram_ctrl.sv | 108 ++++++++++
 tb/tb_ram_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the single-port RAM controller.
// State encoding, default geometry and the bus-drive rule.
package ram_ctrl_pkg;

  localparam int unsigned RC_AW = 4;
  localparam int unsigned RC_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RSP      = 3'd4
  } state_e;

  // The controller owns the data bus only for a pure write cycle.
  function automatic logic bus_drive(input logic we, input logic re);
    return we && !re;
  endfunction

endpackage

// File: rtl/ram_ctrl.sv
// Host-to-RAM controller: one outstanding request, 1-cycle write,
// 2-cycle read with response handshake, shared tri-state data bus.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AW = RC_AW,
  parameter int unsigned DW = RC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_done,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic          re_q;
  logic          rsp_valid_q;
  logic          wr_done_q;
  logic          drive;

  // Ready is gated by rst_n so it is low while reset is held.
  assign req_ready = rst_n && (state_q == ST_IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign wr_done   = wr_done_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_addr  = addr_q;

  // Tri-state driver for the shared RAM data bus.
  assign drive    = bus_drive(we_q, re_q);
  assign mem_data = drive ? wdata_q : {DW{1'bz}};

  // Transaction FSM with registered RAM strobes and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_wr) begin
              state_q <= ST_WR;
              we_q    <= 1'b1;
              re_q    <= 1'b0;
            end else begin
              state_q <= ST_RD_ISSUE;
              we_q    <= 1'b0;
              re_q    <= 1'b1;
            end
          end
        end
        ST_WR: begin
          we_q      <= 1'b0;
          wr_done_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          state_q <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          rdata_q     <= mem_data;
          re_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl with a behavioural 16x8 single-port RAM.
// Table vectors, directed corner cases and a random model run.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       wr_done;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;

  int total = 0;
  int bad = 0;

  logic [7:0] ram [16];
  logic [7:0] ram_q;
  logic [7:0] model [16];

  always #5 clk = ~clk;

  ram_ctrl #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // Behavioural RAM: write on we&&!re, latch read on re&&!we.
  always @(posedge clk) begin
    if (mem_we && !mem_re) ram[mem_addr] <= mem_data;
    if (mem_re && !mem_we) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_re && !mem_we) ? ram_q : 8'hzz;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (rst_n) chk("we_re_excl", {31'd0, mem_we && mem_re}, 32'd0);
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, n < 20}, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wait_ready("wr_ready_to");
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 4'($urandom);
    req_wdata = 8'($urandom);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_re", {31'd0, mem_re}, 32'd0);
    chk("wr_addr", {28'd0, mem_addr}, {28'd0, a});
    chk("wr_bus", {24'd0, mem_data}, {24'd0, d});
    chk("wr_busy", {31'd0, req_ready}, 32'd0);
    chk("wr_done_early", {31'd0, wr_done}, 32'd0);
    @(negedge clk);
    chk("wr_we_off", {31'd0, mem_we}, 32'd0);
    chk("wr_done", {31'd0, wr_done}, 32'd1);
    chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
    chk("wr_ram", {24'd0, ram[a]}, {24'd0, d});
    model[a] = d;
    @(negedge clk);
    chk("wr_done_pulse", {31'd0, wr_done}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input int hold,
                         input logic [7:0] exp);
    wait_ready("rd_ready_to");
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 4'($urandom);
    chk("rd_issue_re", {31'd0, mem_re}, 32'd1);
    chk("rd_issue_we", {31'd0, mem_we}, 32'd0);
    chk("rd_issue_addr", {28'd0, mem_addr}, {28'd0, a});
    chk("rd_issue_busy", {31'd0, req_ready}, 32'd0);
    chk("rd_issue_vld", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_capt_re", {31'd0, mem_re}, 32'd1);
    chk("rd_capt_addr", {28'd0, mem_addr}, {28'd0, a});
    chk("rd_capt_vld", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_vld", {31'd0, rsp_valid}, 32'd1);
    chk("rd_data", {24'd0, rsp_rdata}, {24'd0, exp});
    chk("rd_re_off", {31'd0, mem_re}, 32'd0);
    chk("rd_addr_hold", {28'd0, mem_addr}, {28'd0, a});
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_wdata = ~exp;
      @(negedge clk);
      chk("rsp_hold_vld", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_hold_data", {24'd0, rsp_rdata}, {24'd0, exp});
      chk("rsp_hold_busy", {31'd0, req_ready}, 32'd0);
      chk("rsp_hold_nowr", {31'd0, mem_we}, 32'd0);
    end
    req_valid = 1'b0;
    req_wr    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]   = 8'h00;
      model[i] = 8'h00;
    end
    ram_q = 8'h00;

    tbl[0] = '{1'b1, 4'h3, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 4'h3, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 4'h0, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 4'hF, 8'hFF, 8'h00};
    tbl[4] = '{1'b0, 4'hF, 8'h00, 8'hFF};
    tbl[5] = '{1'b0, 4'h0, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 4'hF, 8'h5C, 8'h00};
    tbl[7] = '{1'b0, 4'hF, 8'h00, 8'h5C};

    // Reset values while reset is held.
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_done", {31'd0, wr_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
      else do_read(tbl[i].addr, 0, tbl[i].exp);
    end

    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i));
    for (int i = 0; i < 16; i++) do_read(4'(i), 0, 8'(i));

    do_read(4'hF, 5, 8'h0F);

    // Reset during RD_CAPT discards the read.
    do_write(4'h5, 8'h5A);
    do_read(4'h5, 0, 8'h5A);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 4'h9;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_re", {31'd0, mem_re}, 32'd0);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("mid_rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("mid_rst_done", {31'd0, wr_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_vld", {31'd0, rsp_valid}, 32'd0);
      chk("mid_no_re", {31'd0, mem_re}, 32'd0);
    end
    do_write(4'h0, 8'hC3);
    do_read(4'h0, 1, 8'hC3);

    // Random traffic against the array model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'($urandom);
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) do_write(a, d);
      else do_read(a, int'($urandom_range(3, 0)), model[a]);
    end

    for (int i = 0; i < 16; i++)
      chk("final_ram", {24'd0, ram[i]}, {24'd0, model[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
